// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and memory-side signals of the shared memory port arbiter.
// The arbiter uses the master view; requesters and memory model use the slave view.
interface mem_bus_arbiter_if #(
  parameter int unsigned NREQ = 3
);
  logic [32*NREQ-1:0] req_addr;
  logic [32*NREQ-1:0] req_wdata;
  logic [2*NREQ-1:0]  req_width;
  logic [NREQ-1:0]    req_read;
  logic [NREQ-1:0]    req_write;
  logic [NREQ-1:0]    req_ok;
  logic [NREQ-1:0]    req_err;
  logic [31:0]        req_rdata;

  logic [31:0]        mem_addr;
  logic [31:0]        mem_wdata;
  logic [1:0]         mem_width;
  logic               mem_read;
  logic               mem_write;
  logic [31:0]        mem_rdata;
  logic               mem_ok;

  modport master (
    input  req_addr, req_wdata, req_width, req_read, req_write,
    output req_ok, req_err, req_rdata,
    output mem_addr, mem_wdata, mem_width, mem_read, mem_write,
    input  mem_rdata, mem_ok
  );

  modport slave (
    output req_addr, req_wdata, req_width, req_read, req_write,
    input  req_ok, req_err, req_rdata,
    input  mem_addr, mem_wdata, mem_width, mem_read, mem_write,
    output mem_rdata, mem_ok
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between NREQ masters, one transaction
// at a time, with a watchdog that aborts a transaction the memory never answers.
module mem_bus_arbiter #(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned GW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  mem_bus_arbiter_if.master bus,
  output logic [GW-1:0]     grant_id,
  output logic              busy
);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t          state;
  logic [GW-1:0]   rr_ptr;
  logic [CNT_W-1:0] wdog;

  logic [NREQ-1:0] pending;
  logic            win_found;
  logic [GW-1:0]   win_id;
  logic [GW-1:0]   idx;

  logic [31:0]     sel_addr;
  logic [31:0]     sel_wdata;
  logic [1:0]      sel_width;
  logic            sel_read;
  logic            sel_write;
  logic            active;
  logic            timeout;
  logic [NREQ-1:0] grant_onehot;

  assign pending      = bus.req_read | bus.req_write;
  assign busy         = (state == S_BUSY);
  assign grant_onehot = NREQ'(1) << grant_id;

  // Round-robin search starting just after the last winner
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = GW'((32'(rr_ptr) + k) % NREQ);
      if (!win_found && pending[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  // Select the granted requester's slice
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_width = 2'd2;
    sel_read  = 1'b0;
    sel_write = 1'b0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (grant_id == GW'(j)) begin
        sel_addr  = bus.req_addr[32*j +: 32];
        sel_wdata = bus.req_wdata[32*j +: 32];
        sel_width = bus.req_width[2*j +: 2];
        sel_read  = bus.req_read[j];
        sel_write = bus.req_write[j];
      end
    end
  end

  assign active  = busy && (sel_read || sel_write);
  assign timeout = active && !bus.mem_ok && (wdog == CNT_W'(TIMEOUT - 1));

  // Memory-side drive and completion pulses; read data is never gated
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_width = 2'd2;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.req_ok    = '0;
    bus.req_err   = '0;
    if (busy) begin
      bus.mem_addr  = sel_addr;
      bus.mem_wdata = sel_wdata;
      bus.mem_width = sel_width;
      bus.mem_write = active && sel_write;
      bus.mem_read  = active && sel_read && !sel_write;
      if (active && bus.mem_ok) begin
        bus.req_ok = grant_onehot;
      end
      if (timeout) begin
        bus.req_err = grant_onehot;
      end
    end
  end

  assign bus.req_rdata = bus.mem_rdata;

  // Ownership state, round-robin pointer and watchdog
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      grant_id <= '0;
      rr_ptr   <= GW'(NREQ - 1);
      wdog     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            state    <= S_BUSY;
            grant_id <= win_id;
            rr_ptr   <= win_id;
            wdog     <= '0;
          end
        end
        S_BUSY: begin
          if (!active || bus.mem_ok || timeout) begin
            state <= S_IDLE;
          end else begin
            wdog <= wdog + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reset, single read, round-robin order,
// write precedence, watchdog timeout and requester abort.
module tb_mem_bus_arbiter;
  localparam int unsigned NREQ = 3;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] grant_id;
  logic       busy;

  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.NREQ(NREQ)) bus ();

  mem_bus_arbiter #(
    .NREQ   (NREQ),
    .TIMEOUT(4),
    .CNT_W  (8)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .bus     (bus),
    .grant_id(grant_id),
    .busy    (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic clear_inputs();
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_width = '0;
    bus.req_read  = '0;
    bus.req_write = '0;
    bus.mem_rdata = '0;
    bus.mem_ok    = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    // 1: reset, including mid-transaction
    rstn = 1'b0;
    clear_inputs();
    sample();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_grant", 32'(grant_id), 32'd0);
    check_eq("rst_width", 32'(bus.mem_width), 32'd2);
    check_eq("rst_rd", 32'(bus.mem_read), 32'd0);
    #1 rstn = 1'b1;
    bus.req_read = 3'b010;
    sample();
    check_eq("t1_busy", 32'(busy), 32'd1);
    check_eq("t1_grant", 32'(grant_id), 32'd1);
    check_eq("t1_rd", 32'(bus.mem_read), 32'd1);
    #1 rstn = 1'b0;
    #1;
    check_eq("t1_rst_rd", 32'(bus.mem_read), 32'd0);
    check_eq("t1_rst_busy", 32'(busy), 32'd0);
    check_eq("t1_rst_grant", 32'(grant_id), 32'd0);
    bus.req_read = 3'b011;
    @(posedge clk);
    #1 rstn = 1'b1;
    sample();
    check_eq("t1_idle_after", 32'(busy), 32'd0);
    next_cycle();
    sample();
    check_eq("t1_rr_busy", 32'(busy), 32'd1);
    check_eq("t1_rr_grant0", 32'(grant_id), 32'd0);

    // 2: single read acknowledged in the third BUSY cycle
    do_reset();
    bus.req_addr[31:0] = 32'h0800_0000;
    bus.req_width[1:0] = 2'd2;
    bus.req_read       = 3'b001;
    sample();
    check_eq("t2_c0_busy", 32'(busy), 32'd0);
    check_eq("t2_c0_rd", 32'(bus.mem_read), 32'd0);
    for (int c = 1; c <= 2; c++) begin
      next_cycle();
      sample();
      check_eq("t2_addr", bus.mem_addr, 32'h0800_0000);
      check_eq("t2_rd", 32'(bus.mem_read), 32'd1);
      check_eq("t2_no_ok", 32'(bus.req_ok), 32'd0);
    end
    next_cycle();
    bus.mem_ok    = 1'b1;
    bus.mem_rdata = 32'hE3A0_0001;
    sample();
    check_eq("t2_c3_addr", bus.mem_addr, 32'h0800_0000);
    check_eq("t2_c3_ok", 32'(bus.req_ok), 32'b001);
    check_eq("t2_c3_rdata", bus.req_rdata, 32'hE3A0_0001);
    check_eq("t2_c3_err", 32'(bus.req_err), 32'd0);
    next_cycle();
    bus.mem_ok   = 1'b0;
    bus.req_read = 3'b000;
    sample();
    check_eq("t2_c4_busy", 32'(busy), 32'd0);
    check_eq("t2_c4_ok", 32'(bus.req_ok), 32'd0);
    check_eq("t2_c4_addr", bus.mem_addr, 32'd0);

    // 3: round-robin with all three requesting and one-cycle memory
    do_reset();
    bus.req_read = 3'b111;
    bus.mem_ok   = 1'b1;
    sample();
    check_eq("t3_c0_busy", 32'(busy), 32'd0);
    for (int c = 1; c <= 12; c++) begin
      next_cycle();
      sample();
      if (c % 2 == 1) begin
        check_eq("t3_busy", 32'(busy), 32'd1);
        check_eq("t3_grant", 32'(grant_id), 32'(((c - 1) / 2) % 3));
        check_eq("t3_ok", 32'(bus.req_ok), 32'd1 << (((c - 1) / 2) % 3));
      end else begin
        check_eq("t3_idle", 32'(busy), 32'd0);
        check_eq("t3_idle_ok", 32'(bus.req_ok), 32'd0);
      end
    end

    // 4: write wins over read
    do_reset();
    bus.req_addr[95:64]  = 32'h0000_0100;
    bus.req_wdata[95:64] = 32'h1234_5678;
    bus.req_width[5:4]   = 2'd1;
    bus.req_read         = 3'b100;
    bus.req_write        = 3'b100;
    sample();
    check_eq("t4_c0_wr", 32'(bus.mem_write), 32'd0);
    next_cycle();
    bus.mem_ok = 1'b1;
    sample();
    check_eq("t4_grant", 32'(grant_id), 32'd2);
    check_eq("t4_wr", 32'(bus.mem_write), 32'd1);
    check_eq("t4_rd", 32'(bus.mem_read), 32'd0);
    check_eq("t4_wdata", bus.mem_wdata, 32'h1234_5678);
    check_eq("t4_width", 32'(bus.mem_width), 32'd1);
    check_eq("t4_addr", bus.mem_addr, 32'h0000_0100);
    check_eq("t4_ok", 32'(bus.req_ok), 32'b100);
    next_cycle();
    clear_inputs();
    sample();
    check_eq("t4_done", 32'(busy), 32'd0);

    // 5: watchdog abort on 4th BUSY cycle, then mem_ok beating the timeout
    do_reset();
    bus.req_read = 3'b010;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      sample();
      check_eq("t5_busy", 32'(busy), 32'd1);
      check_eq("t5_err", 32'(bus.req_err), (c == 4) ? 32'b010 : 32'd0);
      check_eq("t5_ok", 32'(bus.req_ok), 32'd0);
    end
    next_cycle();
    sample();
    check_eq("t5_c5_busy", 32'(busy), 32'd0);
    check_eq("t5_c5_err", 32'(bus.req_err), 32'd0);
    for (int c = 6; c <= 9; c++) begin
      next_cycle();
      if (c == 9) bus.mem_ok = 1'b1;
      sample();
      check_eq("t5_re_busy", 32'(busy), 32'd1);
      check_eq("t5_re_grant", 32'(grant_id), 32'd1);
      check_eq("t5_re_ok", 32'(bus.req_ok), (c == 9) ? 32'b010 : 32'd0);
      check_eq("t5_re_err", 32'(bus.req_err), 32'd0);
    end
    next_cycle();
    clear_inputs();
    sample();
    check_eq("t5_done", 32'(busy), 32'd0);

    // 6: granted requester abandons its request
    do_reset();
    bus.req_addr[63:32] = 32'h2000_0000;
    bus.req_read        = 3'b011;
    sample();
    next_cycle();
    sample();
    check_eq("t6_grant0", 32'(grant_id), 32'd0);
    check_eq("t6_rd", 32'(bus.mem_read), 32'd1);
    next_cycle();
    bus.req_read = 3'b010;
    sample();
    check_eq("t6_drop_rd", 32'(bus.mem_read), 32'd0);
    check_eq("t6_drop_ok", 32'(bus.req_ok), 32'd0);
    check_eq("t6_drop_err", 32'(bus.req_err), 32'd0);
    next_cycle();
    sample();
    check_eq("t6_idle", 32'(busy), 32'd0);
    next_cycle();
    sample();
    check_eq("t6_busy1", 32'(busy), 32'd1);
    check_eq("t6_grant1", 32'(grant_id), 32'd1);
    check_eq("t6_rd1", 32'(bus.mem_read), 32'd1);
    check_eq("t6_addr1", bus.mem_addr, 32'h2000_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
